// File: rtl/fpga_mem_arbiter_if.sv
// Handshake bundle between the memory-port arbiter, its requesters and the
// block-RAM request/response channels.
//   cli_req_val/rdy/msg   per-requester request channel (msg: slice i = requester i)
//   cli_resp_val/rdy      per-requester response handshake
//   cli_resp_msg          shared response payload
//   mem_req_val/rdy/msg   request channel toward memory
//   mem_resp_val/rdy/msg  in-order response channel from memory
// Modports: slave = arbiter side, master = environment (requesters + memory).
interface fpga_mem_arbiter_if #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_msg_bits = 77
);
  logic [p_num_reqs-1:0]            cli_req_val;
  logic [p_num_reqs-1:0]            cli_req_rdy;
  logic [p_num_reqs*p_msg_bits-1:0] cli_req_msg;
  logic [p_num_reqs-1:0]            cli_resp_val;
  logic [p_num_reqs-1:0]            cli_resp_rdy;
  logic [p_msg_bits-1:0]            cli_resp_msg;
  logic                             mem_req_val;
  logic                             mem_req_rdy;
  logic [p_msg_bits-1:0]            mem_req_msg;
  logic                             mem_resp_val;
  logic                             mem_resp_rdy;
  logic [p_msg_bits-1:0]            mem_resp_msg;

  modport slave (
    input  cli_req_val, cli_req_msg, cli_resp_rdy,
    input  mem_req_rdy, mem_resp_val, mem_resp_msg,
    output cli_req_rdy, cli_resp_val, cli_resp_msg,
    output mem_req_val, mem_req_msg, mem_resp_rdy
  );

  modport master (
    output cli_req_val, cli_req_msg, cli_resp_rdy,
    output mem_req_rdy, mem_resp_val, mem_resp_msg,
    input  cli_req_rdy, cli_resp_val, cli_resp_msg,
    input  mem_req_val, mem_req_msg, mem_resp_rdy
  );
endinterface

// File: rtl/fpga_mem_arbiter.sv
// Round-robin arbiter sharing the single block-RAM port among p_num_reqs
// requesters. Grants are combinational (zero added latency); each accepted
// request pushes the grantee ID into a route FIFO, and since memory answers
// in request order the FIFO head steers each response back.
// Ports:
//   mem_clk      clock
//   rst          synchronous active-high reset
//   bus          fpga_mem_arbiter_if.slave (requester and memory channels)
//   outstanding  route FIFO occupancy (p_max_out when full)
//   err_orphan   sticky: memory response arrived with no request outstanding
// Build option: define FPGA_MEM_ARB_PRIO_EN to make requester 0 strict
// high priority; the round-robin pointer then only moves on grants to 1..N-1.
module fpga_mem_arbiter #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned p_msg_bits = 77,
  parameter int unsigned p_max_out  = 4
) (
  input  logic                       mem_clk,
  input  logic                       rst,
  fpga_mem_arbiter_if.slave          bus,
  output logic [$clog2(p_max_out):0] outstanding,
  output logic                       err_orphan
);

  localparam int unsigned ID_W  = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
  localparam int unsigned PTR_W = (p_max_out > 1) ? $clog2(p_max_out) : 1;
  localparam int unsigned CNT_W = $clog2(p_max_out) + 1;
  localparam logic [ID_W:0]    NREQ_X = (ID_W+1)'(p_num_reqs);
  localparam logic [CNT_W-1:0] MAXO_X = CNT_W'(p_max_out);

  typedef logic [ID_W-1:0] id_t;

  id_t              rr_ptr_q, rr_ptr_d;
  id_t              route_q [p_max_out];
  id_t              route_d [p_max_out];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_orphan_q, err_orphan_d;

  id_t  winner;
  id_t  head;
  logic any_val;
  logic full;
  logic empty;
  logic req_xfer;
  logic resp_xfer;

  assign full        = (count_q == MAXO_X);
  assign empty       = (count_q == '0);
  assign any_val     = |bus.cli_req_val;
  assign head        = route_q[rd_ptr_q];
  assign outstanding = count_q;
  assign err_orphan  = err_orphan_q;

  // Winner: first valid requester at or after rr_ptr, wrapping mod p_num_reqs.
  always_comb begin
    logic [ID_W:0] scan;
    logic          found;
    winner = rr_ptr_q;
    found  = 1'b0;
    scan   = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= NREQ_X) scan = scan - NREQ_X;
      if (!found && bus.cli_req_val[scan[ID_W-1:0]]) begin
        winner = scan[ID_W-1:0];
        found  = 1'b1;
      end
    end
`ifdef FPGA_MEM_ARB_PRIO_EN
    if (bus.cli_req_val[0]) winner = '0;
`endif
  end

  // Request side. A full FIFO blocks grants even if a pop lands this cycle.
  always_comb begin
    bus.mem_req_val = any_val & ~full;
    bus.mem_req_msg = '0;
    bus.cli_req_rdy = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      if (winner == id_t'(k)) bus.mem_req_msg = bus.cli_req_msg[k*p_msg_bits +: p_msg_bits];
    end
    if (any_val && !full && bus.mem_req_rdy) bus.cli_req_rdy[winner] = 1'b1;
  end

  assign req_xfer = any_val & ~full & bus.mem_req_rdy;

  // Response side: only the FIFO head may receive, so a stalled head blocks all.
  always_comb begin
    bus.cli_resp_val = '0;
    bus.cli_resp_msg = bus.mem_resp_msg;
    bus.mem_resp_rdy = 1'b0;
    if (!empty) begin
      bus.cli_resp_val[head] = bus.mem_resp_val;
      bus.mem_resp_rdy       = bus.cli_resp_rdy[head];
    end
  end

  assign resp_xfer = bus.mem_resp_val & bus.mem_resp_rdy;

  always_comb begin
    logic [ID_W:0] rr_sum;
    rr_ptr_d     = rr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    route_d      = route_q;
    err_orphan_d = err_orphan_q | (bus.mem_resp_val & empty);

    rr_sum = {1'b0, winner} + (ID_W+1)'(1);
    if (rr_sum == NREQ_X) rr_sum = '0;

    if (req_xfer) begin
      route_d[wr_ptr_q] = winner;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
`ifdef FPGA_MEM_ARB_PRIO_EN
      if (winner != '0) rr_ptr_d = rr_sum[ID_W-1:0];
`else
      rr_ptr_d = rr_sum[ID_W-1:0];
`endif
    end

    if (resp_xfer) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({req_xfer, resp_xfer})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Route entries are only read while occupied, so they need no reset.
  always_ff @(posedge mem_clk) begin
    route_q <= route_d;
  end

endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// Self-checking bench for fpga_mem_arbiter: a queue-based reference model
// predicts every output each cycle; directed scenarios pin literal values.
module tb_fpga_mem_arbiter;
  localparam int N    = 4;
  localparam int MB   = 77;
  localparam int MAXO = 4;

  logic mem_clk = 1'b0;
  logic rst;
  logic [$clog2(MAXO):0] outstanding;
  logic err_orphan;

  fpga_mem_arbiter_if #(.p_num_reqs(N), .p_msg_bits(MB)) bus ();

  fpga_mem_arbiter #(.p_num_reqs(N), .p_msg_bits(MB), .p_max_out(MAXO)) dut (
    .mem_clk    (mem_clk),
    .rst        (rst),
    .bus        (bus),
    .outstanding(outstanding),
    .err_orphan (err_orphan)
  );

  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: routing queue of grantee IDs, round-robin pointer, sticky error.
  int mdl_q[$];
  int mdl_rr    = 0;
  bit mdl_err   = 0;
  bit mdl_valid = 0;
  int grant_log[$];
  int resp_log[$];

  always @(negedge mem_clk) begin
    int w;
    int head;
    bit e_mval, e_mrr, req_x, resp_x;
    logic [N-1:0] e_rdy, e_rval;
    w = -1;
`ifdef FPGA_MEM_ARB_PRIO_EN
    if (bus.cli_req_val[0]) w = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (w < 0 && bus.cli_req_val[(mdl_rr + k) % N]) w = (mdl_rr + k) % N;
    end
    e_mval = (w >= 0) && (mdl_q.size() < MAXO);
    e_rdy  = '0;
    if (e_mval && bus.mem_req_rdy) e_rdy[w] = 1'b1;
    e_rval = '0;
    e_mrr  = 1'b0;
    head   = -1;
    if (mdl_q.size() > 0) begin
      head         = mdl_q[0];
      e_rval[head] = bus.mem_resp_val;
      e_mrr        = bus.cli_resp_rdy[head];
    end

    if (mdl_valid) begin
      chk("mem_req_val", bus.mem_req_val, e_mval);
      if (e_mval) chk("mem_req_msg", bus.mem_req_msg, bus.cli_req_msg[w*MB +: MB]);
      chk("cli_req_rdy", bus.cli_req_rdy, e_rdy);
      chk("cli_resp_val", bus.cli_resp_val, e_rval);
      chk("cli_resp_msg", bus.cli_resp_msg, bus.mem_resp_msg);
      chk("mem_resp_rdy", bus.mem_resp_rdy, e_mrr);
      chk("outstanding", outstanding, mdl_q.size());
      chk("err_orphan", err_orphan, mdl_err);
    end

    if (rst) begin
      mdl_q.delete();
      mdl_rr    = 0;
      mdl_err   = 0;
      mdl_valid = 1;
    end else if (mdl_valid) begin
      req_x  = e_mval && bus.mem_req_rdy;
      resp_x = e_mrr && bus.mem_resp_val;
      if (bus.mem_resp_val && mdl_q.size() == 0) mdl_err = 1;
      if (resp_x) resp_log.push_back(mdl_q.pop_front());
      if (req_x) begin
        grant_log.push_back(w);
        mdl_q.push_back(w);
`ifdef FPGA_MEM_ARB_PRIO_EN
        if (w != 0) mdl_rr = (w + 1) % N;
`else
        mdl_rr = (w + 1) % N;
`endif
      end
    end
  end

  // Memory responder: 0 = forced by mem_force, 1 = answer once two are in flight,
  // 2 = random answers while something is in flight.
  int mem_mode  = 0;
  bit mem_force = 0;

  initial begin
    bus.mem_resp_val = 1'b0;
    bus.mem_resp_msg = '0;
    forever begin
      @(posedge mem_clk);
      #2;
      case (mem_mode)
        1:       bus.mem_resp_val = (mdl_q.size() >= 2);
        2:       bus.mem_resp_val = (mdl_q.size() > 0) && ($urandom_range(0, 2) != 0);
        default: bus.mem_resp_val = mem_force;
      endcase
      bus.mem_resp_msg = MB'({$urandom(), $urandom(), $urandom()});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge mem_clk);
    #1;
  endtask

  task automatic rand_msg();
    for (int b = 0; b < N*MB; b++) bus.cli_req_msg[b] = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    grant_log.delete();
    resp_log.delete();
  endtask

  initial begin
    rst              = 1'b1;
    bus.cli_req_val  = '0;
    bus.cli_req_msg  = '0;
    bus.cli_resp_rdy = '1;
    bus.mem_req_rdy  = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state literals
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_mem_req_val", bus.mem_req_val, 0);
    chk("rst_mem_resp_rdy", bus.mem_resp_rdy, 0);

    // 1: all valid, looped responses -> 0,1,2,3,0,... and in-order returns
    do_reset();
    mem_mode = 1;
    bus.cli_req_val = '1;
    bus.mem_req_rdy = 1'b1;
    for (int c = 0; c < 40 && grant_log.size() < 8; c++) begin
      rand_msg();
      step(1);
    end
    chk("t1_ngrant", grant_log.size() >= 8, 1);
    for (int k = 0; k < 8; k++) chk("t1_grant", grant_log[k], k % 4);
    chk("t1_nresp", resp_log.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk("t1_resp", resp_log[k], k);
    bus.cli_req_val = '0;
    mem_mode = 0;

    // 2: responses blocked -> exactly four in flight, then drain in order
    do_reset();
    bus.cli_resp_rdy = '0;
    bus.cli_req_val  = '1;
    bus.mem_req_rdy  = 1'b1;
    step(8);
    chk("t2_full", outstanding, 4);
    chk("t2_req_val", bus.mem_req_val, 0);
    chk("t2_ngrant", grant_log.size(), 4);
    bus.cli_req_val  = '0;
    bus.cli_resp_rdy = '1;
    mem_force = 1;
    step(4);
    mem_force = 0;
    chk("t2_drained", outstanding, 0);
    chk("t2_nresp", resp_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_resp", resp_log[k], k);
    step(1);
    chk("t2_err", err_orphan, 0);

    // 3: lone requester 2 stalled by memory, then granted; pointer lands on 3
    do_reset();
    bus.cli_req_val = 4'b0100;
    bus.mem_req_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t3_stall_rdy", bus.cli_req_rdy, 4'b0000);
      chk("t3_stall_val", bus.mem_req_val, 1);
    end
    bus.mem_req_rdy = 1'b1;
    #1;
    chk("t3_grant", bus.cli_req_rdy, 4'b0100);
    step(1);
    bus.cli_req_val = '1;
    #1;
    chk("t3_next_rr", bus.cli_req_rdy, 4'b1000);
    bus.cli_req_val = '0;
    bus.mem_req_rdy = 1'b0;

    // 4: head-of-line blocking on requester 1
    do_reset();
    bus.mem_req_rdy = 1'b1;
    bus.cli_req_val = 4'b0010;
    step(1);
    bus.cli_req_val = 4'b0100;
    step(1);
    bus.cli_req_val  = '0;
    bus.cli_resp_rdy = 4'b1101;
    mem_force = 1;
    step(3);
    chk("t4_mem_resp_rdy", bus.mem_resp_rdy, 0);
    chk("t4_resp_val", bus.cli_resp_val, 4'b0010);
    chk("t4_outstanding", outstanding, 2);
    mem_force = 0;
    bus.cli_resp_rdy = '1;

    // 5: orphan response sets a sticky error cleared only by reset
    do_reset();
    bus.mem_req_rdy = 1'b0;
    mem_force = 1;
    step(2);
    chk("t5_err_set", err_orphan, 1);
    chk("t5_rdy", bus.mem_resp_rdy, 0);
    chk("t5_resp_val", bus.cli_resp_val, 4'b0000);
    mem_force = 0;
    step(2);
    chk("t5_err_sticky", err_orphan, 1);
    do_reset();
    chk("t5_err_clr", err_orphan, 0);

    // 6: requesters 0 and 1 both valid
    do_reset();
    mem_mode = 1;
    bus.mem_req_rdy = 1'b1;
    bus.cli_req_val = 4'b0011;
    step(6);
    chk("t6_ngrant", grant_log.size() >= 5, 1);
`ifdef FPGA_MEM_ARB_PRIO_EN
    for (int k = 0; k < 5; k++) chk("t6_prio", grant_log[k], 0);
`else
    for (int k = 0; k < 5; k++) chk("t6_rr", grant_log[k], k % 2);
`endif
    bus.cli_req_val = 4'b0010;
    grant_log.delete();
    step(2);
    chk("t6_drop0", grant_log[0], 1);
    bus.cli_req_val = '0;
    mem_mode = 0;

    // Random traffic, with one reset landing mid-transaction
    do_reset();
    mem_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      bus.cli_req_val  = N'($urandom());
      bus.mem_req_rdy  = ($urandom_range(0, 3) != 0);
      bus.cli_resp_rdy = N'($urandom() | $urandom());
      rand_msg();
      rst = (i == 1500);
      step(1);
    end
    rst = 1'b0;
    bus.cli_req_val = '0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
